// File: rtl/huff_pkg.sv
// Shared Huffman code definitions for the encoder/decoder pair: symbol width,
// left-aligned codewords and their lengths, plus the illegal-symbol encoding.
package huff_pkg;

    localparam int SYM_W   = 3;
    localparam int MAX_LEN = 4;
    localparam int LEN_W   = 3;

    typedef logic [SYM_W-1:0]   sym_t;
    typedef logic [MAX_LEN-1:0] code_t;
    typedef logic [LEN_W-1:0]   len_t;

    // Codewords are left-aligned so the transmit bit is always code[MAX_LEN-1].
    localparam code_t CODE_1 = 4'b0000;
    localparam code_t CODE_2 = 4'b1010;
    localparam code_t CODE_3 = 4'b1000;
    localparam code_t CODE_4 = 4'b1110;
    localparam code_t CODE_5 = 4'b1101;
    localparam code_t CODE_6 = 4'b1100;

    localparam len_t LEN_1 = 3'd1;
    localparam len_t LEN_2 = 3'd3;
    localparam len_t LEN_3 = 3'd3;
    localparam len_t LEN_4 = 3'd3;
    localparam len_t LEN_5 = 3'd4;
    localparam len_t LEN_6 = 3'd4;

    localparam code_t CODE_ILLEGAL = 4'b0000;
    localparam len_t  LEN_ILLEGAL  = 3'd0;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } enc_state_t;

    typedef struct packed {
        code_t code;
        len_t  len;
        logic  legal;
    } rom_entry_t;

    function automatic rom_entry_t code_lookup(input sym_t s);
        rom_entry_t e;
        case (s)
            3'd1:    e = '{code: CODE_1, len: LEN_1, legal: 1'b1};
            3'd2:    e = '{code: CODE_2, len: LEN_2, legal: 1'b1};
            3'd3:    e = '{code: CODE_3, len: LEN_3, legal: 1'b1};
            3'd4:    e = '{code: CODE_4, len: LEN_4, legal: 1'b1};
            3'd5:    e = '{code: CODE_5, len: LEN_5, legal: 1'b1};
            3'd6:    e = '{code: CODE_6, len: LEN_6, legal: 1'b1};
            default: e = '{code: CODE_ILLEGAL, len: LEN_ILLEGAL, legal: 1'b0};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/huff_code_rom.sv
// Combinational symbol-to-codeword table: sym -> {code, len, legal}.
module huff_code_rom
    import huff_pkg::*;
(
    input  logic [SYM_W-1:0]   sym,
    output logic [MAX_LEN-1:0] code,
    output logic [LEN_W-1:0]   len,
    output logic               legal
);

    rom_entry_t entry;

    always_comb begin
        entry = code_lookup(sym);
    end

    assign code  = entry.code;
    assign len   = entry.len;
    assign legal = entry.legal;

endmodule

// File: rtl/huffman_encoder.sv
// Serial Huffman encoder: symbols in over valid/ready, codewords out MSB-first
// one bit per clock with no gaps between back-to-back symbols.
// Optional sticky illegal-symbol flag 'err' is built when HUFF_ENC_ERR_EN is defined.
module huffman_encoder
    import huff_pkg::*;
#(
    parameter logic IDLE_BIT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SYM_W-1:0] sym,
    input  logic             sym_valid,
    output logic             sym_ready,
    output logic             x,
    output logic             x_valid,
    output logic             x_last
`ifdef HUFF_ENC_ERR_EN
    ,
    output logic             err
`endif
);

    enc_state_t state;
    enc_state_t next_state;

    code_t shreg;
    code_t next_shreg;
    len_t  cnt;
    len_t  next_cnt;
    logic  next_x;
    logic  next_x_valid;
    logic  next_x_last;

    code_t rom_code;
    len_t  rom_len;
    logic  rom_legal;
    logic  accept;
    logic  load;

    huff_code_rom u_rom (
        .sym   (sym),
        .code  (rom_code),
        .len   (rom_len),
        .legal (rom_legal)
    );

    // Ready depends only on state so a sender may wait on it before raising valid.
    assign sym_ready = (state == ST_IDLE) || (cnt == 3'd1);
    assign accept    = sym_valid && sym_ready;
    assign load      = accept && rom_legal;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if ((cnt == 3'd1) && !load) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // A legal accept always wins: it can only happen in IDLE or on the final bit,
    // which is what lets a new codeword follow the old one without a bubble.
    always_comb begin
        next_shreg   = shreg;
        next_cnt     = cnt;
        next_x       = x;
        next_x_valid = x_valid;
        next_x_last  = x_last;
        if (load) begin
            next_x       = rom_code[MAX_LEN-1];
            next_shreg   = rom_code << 1;
            next_cnt     = rom_len;
            next_x_valid = 1'b1;
            next_x_last  = (rom_len == 3'd1);
        end else if ((state == ST_SHIFT) && (cnt > 3'd1)) begin
            next_x       = shreg[MAX_LEN-1];
            next_shreg   = shreg << 1;
            next_cnt     = cnt - 3'd1;
            next_x_valid = 1'b1;
            next_x_last  = (cnt == 3'd2);
        end else begin
            next_x       = IDLE_BIT;
            next_shreg   = '0;
            next_cnt     = '0;
            next_x_valid = 1'b0;
            next_x_last  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            shreg   <= '0;
            cnt     <= '0;
            x       <= IDLE_BIT;
            x_valid <= 1'b0;
            x_last  <= 1'b0;
        end else begin
            shreg   <= next_shreg;
            cnt     <= next_cnt;
            x       <= next_x;
            x_valid <= next_x_valid;
            x_last  <= next_x_last;
        end
    end

`ifdef HUFF_ENC_ERR_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (accept && !rom_legal) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_huffman_encoder.sv
// Self-checking bench for huffman_encoder: a queue-based bit-stream model,
// a loopback prefix decoder, and directed sequences with literal expectations.
module tb_huffman_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] sym;
    logic       sym_valid;
    logic       sym_ready;
    logic       x;
    logic       x_valid;
    logic       x_last;
`ifdef HUFF_ENC_ERR_EN
    logic       err;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    huffman_encoder #(.IDLE_BIT(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .sym       (sym),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .x         (x),
        .x_valid   (x_valid),
        .x_last    (x_last)
`ifdef HUFF_ENC_ERR_EN
        ,
        .err       (err)
`endif
    );

    typedef struct packed {
        logic b;
        logic last;
    } out_bit_t;

    out_bit_t out_q[$];
    int       sent_q[$];
    bit       model_live = 1'b0;
    logic     err_m = 1'b0;
    string    dec_buf = "";

    function automatic string code_of(input int s);
        case (s)
            1:       return "0";
            2:       return "101";
            3:       return "100";
            4:       return "111";
            5:       return "1101";
            6:       return "1100";
            default: return "";
        endcase
    endfunction

    function automatic int decode(input string bits);
        for (int s = 1; s <= 6; s++) begin
            if (code_of(s) == bits) return s;
        end
        return 0;
    endfunction

    task automatic compare(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string name, input logic ex, input logic ev,
                               input logic el, input logic er);
        compare({name, " x"}, x, ex);
        compare({name, " x_valid"}, x_valid, ev);
        compare({name, " x_last"}, x_last, el);
        compare({name, " sym_ready"}, sym_ready, er);
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] s);
        sym_valid = v;
        sym       = s;
        @(negedge clk);
    endtask

    // Model: pending output bits as a queue; the head is what x shows this cycle.
    initial forever begin
        @(posedge clk);
        if (reset === 1'b0) begin
            out_q.delete();
            sent_q.delete();
            err_m      = 1'b0;
            model_live = 1'b1;
        end else if (model_live) begin
            bit       ready_m;
            string    c;
            out_bit_t e;
            ready_m = (out_q.size() <= 1);
            if (out_q.size() > 0) void'(out_q.pop_front());
            if (sym_valid && ready_m) begin
                if (sym >= 3'd1 && sym <= 3'd6) begin
                    c = code_of(int'(sym));
                    for (int i = 0; i < c.len(); i++) begin
                        e.b    = (c[i] == "1");
                        e.last = (i == c.len() - 1);
                        out_q.push_back(e);
                    end
                    sent_q.push_back(int'(sym));
                end else begin
                    err_m = 1'b1;
                end
            end
        end
    end

    // Per-cycle compare against the model plus loopback decoding of the stream.
    initial forever begin
        @(negedge clk);
        if (model_live) begin
            logic exp_v;
            logic exp_x;
            logic exp_l;
            logic exp_r;
            int   got;
            int   want;
            exp_v = (out_q.size() > 0);
            exp_x = exp_v ? out_q[0].b : 1'b1;
            exp_l = exp_v ? out_q[0].last : 1'b0;
            exp_r = (out_q.size() <= 1);
            compare("model x_valid", x_valid, exp_v);
            compare("model x", x, exp_x);
            compare("model x_last", x_last, exp_l);
            compare("model sym_ready", sym_ready, exp_r);
`ifdef HUFF_ENC_ERR_EN
            compare("model err", err, err_m);
`endif
            if (reset === 1'b0) begin
                dec_buf = "";
            end else if (x_valid === 1'b1) begin
                if (x === 1'b1) dec_buf = {dec_buf, "1"};
                else            dec_buf = {dec_buf, "0"};
                if (x_last === 1'b1) begin
                    got = decode(dec_buf);
                    checks++;
                    if (sent_q.size() == 0) begin
                        failures++;
                        $display("[TB] FAIL loopback: decoded %0d but no symbol outstanding", got);
                    end else begin
                        want = sent_q.pop_front();
                        if (got != want) begin
                            failures++;
                            $display("[TB] FAIL loopback: decoded %0d expected %0d (bits %s)", got, want, dec_buf);
                        end
                    end
                    dec_buf = "";
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int perm[6];
        int waited;
        int tmp;
        int j;

        // Reset held with a valid symbol present must emit nothing.
        reset     = 1'b0;
        sym_valid = 1'b1;
        sym       = 3'd5;
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset hold", 1'b1, 1'b0, 1'b0, 1'b1);
        end
        reset     = 1'b1;
        sym_valid = 1'b0;
        @(negedge clk);
        checkOutput("after release", 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef HUFF_ENC_ERR_EN
        compare("err after reset", err, 1'b0);
`endif

        // Single sym=5 -> 1,1,0,1
        applyStimulus(1'b1, 3'd5); checkOutput("sym5 b1", 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd0); checkOutput("sym5 b2", 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd0); checkOutput("sym5 b3", 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd0); checkOutput("sym5 b4", 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 3'd0); checkOutput("sym5 idle", 1'b1, 1'b0, 1'b0, 1'b1);

        // Stream 1,6,3 with valid held -> 0 | 1,1,0,0 | 1,0,0
        applyStimulus(1'b1, 3'd1); checkOutput("str b1", 1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 3'd6); checkOutput("str b2", 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd6); checkOutput("str b3", 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd6); checkOutput("str b4", 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd6); checkOutput("str b5", 1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 3'd3); checkOutput("str b6", 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd0); checkOutput("str b7", 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd0); checkOutput("str b8", 1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 3'd0); checkOutput("str idle", 1'b1, 1'b0, 1'b0, 1'b1);

        // Illegal sym=0 consumed silently, then sym=4 -> 1,1,1
        applyStimulus(1'b1, 3'd0); checkOutput("ill idle", 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef HUFF_ENC_ERR_EN
        compare("err set", err, 1'b1);
`endif
        applyStimulus(1'b1, 3'd4); checkOutput("sym4 b1", 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd0); checkOutput("sym4 b2", 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd0); checkOutput("sym4 b3", 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 3'd0); checkOutput("sym4 idle", 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef HUFF_ENC_ERR_EN
        compare("err sticky", err, 1'b1);
`endif

        // Reset during sym=6, then a clean sym=2 -> 1,0,1
        applyStimulus(1'b1, 3'd6); checkOutput("sym6 b1", 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd0); checkOutput("sym6 b2", 1'b1, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clk); checkOutput("mid reset 1", 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk); checkOutput("mid reset 2", 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef HUFF_ENC_ERR_EN
        compare("err cleared", err, 1'b0);
`endif
        reset = 1'b1;
        applyStimulus(1'b0, 3'd0); checkOutput("post reset", 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 3'd2); checkOutput("sym2 b1", 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd0); checkOutput("sym2 b2", 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd0); checkOutput("sym2 b3", 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 3'd0); checkOutput("sym2 idle", 1'b1, 1'b0, 1'b0, 1'b1);

        // Loopback: every symbol 1..6 in shuffled order, several rounds, random gaps.
        for (int round = 0; round < 4; round++) begin
            for (int i = 0; i < 6; i++) perm[i] = i + 1;
            for (int i = 5; i > 0; i--) begin
                j       = int'($urandom_range(0, i));
                tmp     = perm[i];
                perm[i] = perm[j];
                perm[j] = tmp;
            end
            for (int i = 0; i < 6; i++) begin
                sym_valid = 1'b1;
                sym       = 3'(perm[i]);
                waited    = 0;
                while (sym_ready !== 1'b1 && waited < 10) begin
                    @(negedge clk);
                    waited++;
                end
                if (waited >= 10) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL handshake timeout: sym_ready stayed %b, required 1", sym_ready);
                end
                @(negedge clk);
                if ($urandom_range(0, 2) == 0) begin
                    sym_valid = 1'b0;
                    @(negedge clk);
                end
            end
        end

        sym_valid = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (sent_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: %0d symbols never decoded, required 0", sent_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
